// File: rtl/rfphoenix_ifq_pkg.sv
// Shared types for the instruction fetch queue: instruction/postfix word layouts and opcodes.
// Postfix words carry a 34-bit immediate in the same bit positions as an instruction body.
package rfphoenix_ifq_pkg;

    localparam int IFQ_DEPTH = 8;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_OR   = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h04;
    localparam logic [5:0] OP_XORI = 6'h05;
    localparam logic [5:0] OP_LDW  = 6'h10;
    localparam logic [5:0] OP_PFX  = 6'h3F;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [33:0] body;
    } Instruction;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [33:0] imm;
    } Postfix;

    typedef struct packed {
        Instruction  ir;
        logic [31:0] pc;
    } sIfqEntry;

    localparam Postfix NOP_POSTFIX = '{opcode: OP_NOP, imm: 34'h0};

    function automatic logic is_pfx(input Instruction i);
        return i.opcode == OP_PFX;
    endfunction

endpackage

// File: rtl/rfphoenix_ifq_if.sv
// Fetch-side push and decode-side triple handshake of the instruction fetch queue.
// master drives fetch words and decoder ready; slave is the queue itself.
interface rfphoenix_ifq_if #(parameter int AW = 3);
    import rfphoenix_ifq_pkg::*;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    Instruction  in_ir;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    Instruction  out_ir;
    Postfix      out_pfx;
    logic [31:0] out_pc;
    logic [1:0]  out_len;
    logic        pfx_orphan;
    logic [AW:0] count;

    modport master (
        output flush, in_valid, in_ir, in_pc, out_ready,
        input  in_ready, out_valid, out_ir, out_pfx, out_pc, out_len, pfx_orphan, count
    );

    modport slave (
        input  flush, in_valid, in_ir, in_pc, out_ready,
        output in_ready, out_valid, out_ir, out_pfx, out_pc, out_len, pfx_orphan, count
    );

endinterface

// File: rtl/rfphoenix_ifq_ram.sv
// DEPTH-entry register file, one write port and two asynchronous read ports (head and head+1).
// Write lands on the clock edge; reads are purely combinational from the array.
module rfphoenix_ifq_ram
    import rfphoenix_ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  sIfqEntry      wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output sIfqEntry      rdata0,
    output Instruction    rdata1_ir
);

    sIfqEntry mem_q [DEPTH];

    // Storage is not reset: occupancy in the top module decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata0    = mem_q[raddr0];
    assign rdata1_ir = mem_q[raddr1].ir;

endmodule

// File: rtl/rfphoenix_ifq.sv
// Instruction fetch queue: pairs each instruction with a following PFX word for decode, drops orphan PFX.
// Output valid one cycle after the second word is written; push blocked while full, flush wins over everything.
module rfphoenix_ifq
    import rfphoenix_ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    rfphoenix_ifq_if.slave bus
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] TWO  = (AW+1)'(2);

    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   count_q, count_d;
    logic          orphan_q, orphan_d;

    sIfqEntry      head;
    Instruction    next_ir;
    sIfqEntry      wentry;
    logic          push;
    logic          head_pfx;
    logic          next_pfx;
    logic          out_valid;
    logic          in_ready;
    logic [1:0]    pair_len;
    logic [1:0]    pop_words;

    assign wentry = '{ir: bus.in_ir, pc: bus.in_pc};

    rfphoenix_ifq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk       (clk),
        .we        (push),
        .waddr     (wr_q),
        .wdata     (wentry),
        .raddr0    (rd_q),
        .raddr1    (rd_q + AW'(1)),
        .rdata0    (head),
        .rdata1_ir (next_ir)
    );

    // A lone non-PFX head is held back: its postfix may not have arrived yet.
    assign head_pfx  = (count_q != '0) && is_pfx(head.ir);
    assign next_pfx  = is_pfx(next_ir);
    assign out_valid = !head_pfx && (count_q >= TWO);
    assign pair_len  = next_pfx ? 2'd2 : 2'd1;
    assign in_ready  = (count_q != FULL);
    assign push      = bus.in_valid && in_ready && !bus.flush;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_ir     = head.ir;
    assign bus.out_pc     = head.pc;
    assign bus.out_pfx    = (out_valid && next_pfx) ? Postfix'(next_ir) : NOP_POSTFIX;
    assign bus.out_len    = pair_len;
    assign bus.pfx_orphan = orphan_q;
    assign bus.count      = count_q;

    always_comb begin
        pop_words = 2'd0;
        rd_d      = rd_q;
        wr_d      = wr_q;
        count_d   = count_q;
        orphan_d  = 1'b0;
        if (bus.flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (head_pfx) begin
                pop_words = 2'd1;
            end else if (out_valid && bus.out_ready) begin
                pop_words = pair_len;
            end
            rd_d     = rd_q + AW'(pop_words);
            wr_d     = wr_q + AW'(push);
            count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop_words);
            orphan_d = head_pfx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
            orphan_q <= orphan_d;
        end
    end

endmodule

// File: tb/tb_rfphoenix_ifq.sv
// Directed bench for the instruction fetch queue: pairing, orphan drop, full/wrap, flush, async reset.
module tb_rfphoenix_ifq;
    import rfphoenix_ifq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    rfphoenix_ifq_if #(.AW(3)) ifq();

    rfphoenix_ifq #(.DEPTH(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifq)
    );

    always #5 clk = ~clk;

    function automatic Instruction mk(input logic [5:0] op, input logic [33:0] body);
        Instruction w;
        w.opcode = op;
        w.body   = body;
        return w;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ifq.flush     = 1'b0;
        ifq.in_valid  = 1'b0;
        ifq.in_ir     = '0;
        ifq.in_pc     = '0;
        ifq.out_ready = 1'b0;
    endtask

    task automatic push(input logic [5:0] op, input logic [33:0] body, input logic [31:0] pc);
        ifq.in_valid = 1'b1;
        ifq.in_ir    = mk(op, body);
        ifq.in_pc    = pc;
        step();
        ifq.in_valid = 1'b0;
    endtask

    task automatic pop_one;
        ifq.out_ready = 1'b1;
        step();
        ifq.out_ready = 1'b0;
    endtask

    task automatic do_flush;
        ifq.flush = 1'b1;
        step();
        ifq.flush = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        n_checks++; if (ifq.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ifq.out_valid); end
        n_checks++; if (ifq.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", ifq.in_ready); end
        n_checks++; if (ifq.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", ifq.count); end
        n_checks++; if (ifq.out_pfx !== NOP_POSTFIX) begin n_fail++; $display("FAIL reset_out_pfx: got %h want %h", ifq.out_pfx, NOP_POSTFIX); end
        n_checks++; if (ifq.pfx_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_orphan: got %b want 0", ifq.pfx_orphan); end
    endtask

    task automatic test_single;
        push(OP_ADDI, 34'h11, 32'h100);
        n_checks++; if (ifq.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_hold: got %b want 0", ifq.out_valid); end
        push(OP_XORI, 34'h22, 32'h105);
        n_checks++; if (ifq.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", ifq.out_valid); end
        n_checks++; if (ifq.out_ir !== mk(OP_ADDI, 34'h11)) begin n_fail++; $display("FAIL single_ir: got %h want %h", ifq.out_ir, mk(OP_ADDI, 34'h11)); end
        n_checks++; if (ifq.out_pc !== 32'h100) begin n_fail++; $display("FAIL single_pc: got %h want 100", ifq.out_pc); end
        n_checks++; if (ifq.out_pfx !== NOP_POSTFIX) begin n_fail++; $display("FAIL single_pfx: got %h want %h", ifq.out_pfx, NOP_POSTFIX); end
        n_checks++; if (ifq.out_len !== 2'd1) begin n_fail++; $display("FAIL single_len: got %0d want 1", ifq.out_len); end
        n_checks++; if (ifq.count !== 4'd2) begin n_fail++; $display("FAIL single_count: got %0d want 2", ifq.count); end
        pop_one();
        n_checks++; if (ifq.count !== 4'd1 || ifq.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_pop: got count %0d valid %b want 1/0", ifq.count, ifq.out_valid); end
        do_flush();
    endtask

    task automatic test_pair;
        push(OP_LDW, 34'h7, 32'h200);
        push(OP_PFX, 34'h1234, 32'h205);
        n_checks++; if (ifq.out_valid !== 1'b1 || ifq.out_ir !== mk(OP_LDW, 34'h7)) begin n_fail++; $display("FAIL pair_head: got valid %b ir %h", ifq.out_valid, ifq.out_ir); end
        n_checks++; if (ifq.out_pfx.imm !== 34'h1234 || ifq.out_pfx.opcode !== OP_PFX) begin n_fail++; $display("FAIL pair_pfx: got %h want imm 1234", ifq.out_pfx); end
        n_checks++; if (ifq.out_len !== 2'd2) begin n_fail++; $display("FAIL pair_len: got %0d want 2", ifq.out_len); end
        pop_one();
        n_checks++; if (ifq.count !== 4'd0 || ifq.out_valid !== 1'b0) begin n_fail++; $display("FAIL pair_after_pop: got count %0d valid %b want 0/0", ifq.count, ifq.out_valid); end
    endtask

    task automatic test_orphan;
        push(OP_PFX, 34'h55, 32'h300);
        n_checks++; if (ifq.count !== 4'd1 || ifq.out_valid !== 1'b0 || ifq.pfx_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_stage1: got count %0d valid %b strobe %b", ifq.count, ifq.out_valid, ifq.pfx_orphan); end
        push(OP_ADD, 34'h66, 32'h304);
        n_checks++; if (ifq.pfx_orphan !== 1'b1 || ifq.count !== 4'd1) begin n_fail++; $display("FAIL orphan_strobe: got strobe %b count %0d want 1/1", ifq.pfx_orphan, ifq.count); end
        push(OP_OR, 34'h77, 32'h308);
        n_checks++; if (ifq.pfx_orphan !== 1'b0 || ifq.count !== 4'd2) begin n_fail++; $display("FAIL orphan_once: got strobe %b count %0d want 0/2", ifq.pfx_orphan, ifq.count); end
        n_checks++; if (ifq.out_valid !== 1'b1 || ifq.out_ir !== mk(OP_ADD, 34'h66) || ifq.out_pc !== 32'h304) begin n_fail++; $display("FAIL orphan_next: got valid %b ir %h pc %h", ifq.out_valid, ifq.out_ir, ifq.out_pc); end
        n_checks++; if (ifq.out_pfx !== NOP_POSTFIX || ifq.out_len !== 2'd1) begin n_fail++; $display("FAIL orphan_next_pfx: got %h len %0d", ifq.out_pfx, ifq.out_len); end
        do_flush();
    endtask

    task automatic test_double_pfx;
        push(OP_ADD, 34'h1, 32'h400);
        push(OP_PFX, 34'hA, 32'h405);
        push(OP_PFX, 34'hB, 32'h40A);
        n_checks++; if (ifq.out_valid !== 1'b1 || ifq.out_pfx.imm !== 34'hA || ifq.out_len !== 2'd2) begin n_fail++; $display("FAIL dbl_pair: got valid %b imm %h len %0d", ifq.out_valid, ifq.out_pfx.imm, ifq.out_len); end
        pop_one();
        n_checks++; if (ifq.count !== 4'd1 || ifq.out_valid !== 1'b0) begin n_fail++; $display("FAIL dbl_after_pop: got count %0d valid %b want 1/0", ifq.count, ifq.out_valid); end
        step();
        n_checks++; if (ifq.count !== 4'd0 || ifq.pfx_orphan !== 1'b1) begin n_fail++; $display("FAIL dbl_drop: got count %0d strobe %b want 0/1", ifq.count, ifq.pfx_orphan); end
        step();
        n_checks++; if (ifq.pfx_orphan !== 1'b0) begin n_fail++; $display("FAIL dbl_strobe_clear: got %b want 0", ifq.pfx_orphan); end
    endtask

    task automatic test_full_wrap;
        int p;
        int e;
        int cyc;
        logic fired_in;
        logic fired_out;
        for (int i = 0; i < 8; i++) push(OP_ADD, 34'(i), 32'h1000 + 32'(i) * 4);
        n_checks++; if (ifq.in_ready !== 1'b0 || ifq.count !== 4'd8) begin n_fail++; $display("FAIL full_state: got ready %b count %0d want 0/8", ifq.in_ready, ifq.count); end
        p = 8; e = 0; cyc = 0;
        while (e < 20 && cyc < 200) begin
            ifq.out_ready = 1'b1;
            ifq.in_valid  = (p <= 20);
            ifq.in_ir     = mk(OP_ADD, 34'(p));
            ifq.in_pc     = 32'h1000 + 32'(p) * 4;
            fired_out = ifq.out_valid;
            fired_in  = ifq.in_valid && ifq.in_ready;
            if (ifq.out_valid) begin
                n_checks++;
                if (ifq.out_ir !== mk(OP_ADD, 34'(e)) || ifq.out_pc !== 32'h1000 + 32'(e) * 4 || ifq.out_len !== 2'd1) begin
                    n_fail++; $display("FAIL wrap_word%0d: got ir %h pc %h len %0d", e, ifq.out_ir, ifq.out_pc, ifq.out_len);
                end
            end
            step();
            cyc++;
            if (cyc == 1) begin
                n_checks++; if (ifq.count !== 4'd7 || ifq.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_blocked_push: got count %0d ready %b want 7/1", ifq.count, ifq.in_ready); end
            end
            if (fired_out) e++;
            if (fired_in) p++;
        end
        idle_inputs();
        n_checks++; if (e != 20) begin n_fail++; $display("FAIL wrap_delivered: got %0d words want 20", e); end
        do_flush();
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) push(OP_ADD, 34'h50 + 34'(i), 32'h500 + 32'(i) * 4);
        n_checks++; if (ifq.count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 5", ifq.count); end
        ifq.flush = 1'b1; ifq.in_valid = 1'b1; ifq.in_ir = mk(OP_ADD, 34'h99); ifq.in_pc = 32'h5555; ifq.out_ready = 1'b1;
        step();
        idle_inputs();
        n_checks++; if (ifq.count !== 4'd0 || ifq.out_valid !== 1'b0 || ifq.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state: got count %0d valid %b ready %b", ifq.count, ifq.out_valid, ifq.in_ready); end
        push(OP_OR, 34'h1, 32'h600);
        push(OP_ADD, 34'h2, 32'h604);
        n_checks++; if (ifq.count !== 4'd2 || ifq.out_ir !== mk(OP_OR, 34'h1) || ifq.out_pc !== 32'h600) begin n_fail++; $display("FAIL flush_dropped_push: got count %0d ir %h pc %h", ifq.count, ifq.out_ir, ifq.out_pc); end
        do_flush();
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 4; i++) push(OP_ADD, 34'h70 + 34'(i), 32'h700 + 32'(i) * 4);
        n_checks++; if (ifq.count !== 4'd4 || ifq.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got count %0d valid %b want 4/1", ifq.count, ifq.out_valid); end
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (ifq.out_valid !== 1'b0 || ifq.count !== 4'd0 || ifq.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_immediate: got valid %b count %0d ready %b", ifq.out_valid, ifq.count, ifq.in_ready); end
        #2;
        rst = 1'b0;
        step();
        n_checks++; if (ifq.count !== 4'd0 || ifq.pfx_orphan !== 1'b0) begin n_fail++; $display("FAIL arst_after: got count %0d strobe %b", ifq.count, ifq.pfx_orphan); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_orphan();
        test_double_pfx();
        test_full_wrap();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
